spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
SPI initiator that drives the serial side of our SPI slave: it generates sclk, ssel (active-low), rd_wr and mosi, and it samples miso. A parallel host interface issues one 8-bit write or read per request. Frames match the slave's contract:
- ssel low for the whole frame.
- rd_wr stable for 1 command period plus 8 data periods.
- mosi never X.

Parameters:
CLK_DIV, 4, system clocks per sclk half-period (>=1)
DATA_W, 8, bits per frame (fixed at 8 for current slave; kept for reuse)
IDLE_GAP, 1, minimum sclk periods ssel stays high between frames (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe, accepted only when ready=1
rd_wr_req  input  1  1=write frame, 0=read frame
wr_data  input  DATA_W  write payload, captured on accept
ready  output  1  high only in IDLE
busy  output  1  ~ready
done  output  1  one-clk pulse at frame end
rd_data  output  DATA_W  last read payload
sclk  output  1  free-running serial clock, mode 0 (idle low)
ssel  output  1  slave select, active low
rd_wr  output  1  direction to slave
mosi  output  1  serial out, MSB first
miso  input  1  serial in

Behaviour:
- Reset (async, immediate):
  - sclk=0, ssel=1, rd_wr=0, mosi=0, done=0, rd_data=0, ready=1, state=IDLE.
  - Divider and bit counter are cleared.
  - Reset asserted mid-frame aborts the frame: ssel goes to 1 at once, no done.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and toggles sclk at terminal count.
  - rise_tick = toggle with sclk==0; fall_tick = toggle with sclk==1.
  - sclk runs continuously, including while ssel is high.
  - All serial-side changes occur only on fall_tick. miso is sampled only on rise_tick.
- FSM states: IDLE, WAIT, CMD, DATA, GAP.
  - IDLE: on start&ready, capture rd_wr_req and wr_data into shift_reg and go to WAIT. ready drops the next clk.
  - WAIT: on fall_tick, ssel<=0, rd_wr<=captured dir, mosi<=0, go to CMD.
  - CMD: lasts one sclk period, giving the slave one rising edge to leave its idle state.
    - On the next fall_tick, go to DATA with bit_cnt=DATA_W-1.
    - mosi<=shift_reg MSB on write, 0 on read.
  - DATA:
    - On rise_tick: for a read, shift miso into shift_reg LSB.
    - On fall_tick: if bit_cnt==0, go to GAP; otherwise decrement bit_cnt and present the next MSB on mosi (write) or keep mosi=0 (read).
    - Net result: 8 rising edges with valid data.
  - GAP entry:
    - ssel<=1 and mosi<=0; rd_wr holds its value (no glitch, no X).
    - done pulses for 1 clk.
    - On a read, rd_data<=shift_reg. Writes leave rd_data unchanged.
    - Stay in GAP for IDLE_GAP fall_ticks, then go to IDLE.
- Timing:
  - rd_wr is constant across 9 consecutive sclk rising edges with ssel low.
  - rd_wr changes only at WAIT→CMD.
  - Latency from accept to done is between 9·2·CLK_DIV and 10·2·CLK_DIV clks.
- Boundaries:
  - start while busy is ignored (no queue).
  - start held high produces back-to-back frames separated by >=IDLE_GAP sclk periods of ssel high.
  - done and ready are never high in the same cycle.
  - CLK_DIV=1 gives sclk=clk/2; the FSM must not miss a tick.
  - Inputs are sampled only on accept. Changes to wr_data or rd_wr_req mid-frame have no effect.

Decomposition:
- Package spi_pkg holds:
  - typedef enum logic [2:0] spi_mst_state_e {IDLE, WAIT, CMD, DATA, GAP}
  - localparam SPI_DATA_W = 8
  - slave state encodings ST_IDLE=2'b00, ST_WR=2'b01, ST_RD=2'b10, shared with the slave and its checkers
- One sub-module, spi_clk_div: parameter CLK_DIV; outputs sclk, rise_tick, fall_tick; same clk/rst_n.
- FSM and shift register stay in spi_master_ctrl.

Test Plan:
1. Write 0xA5, CLK_DIV=2, slave model attached:
   - mosi=1,0,1,0,0,1,0,1 on rising edges 2..9 after ssel falls.
   - rd_wr=1 on all 9 edges.
   - Single done pulse; slave captures 0xA5.
2. Read, slave model drives 0x3C:
   - rd_data=0x3C at done.
   - mosi=0 and rd_wr=0 throughout the frame.
   - A following write leaves rd_data at 0x3C.
3. start held high for 3 frames, IDLE_GAP=2:
   - ssel high for >=2 sclk periods between frames.
   - Exactly 3 done pulses.
   - ready never high while done is high.
4. start pulsed during DATA of a write:
   - Ignored; frame completes unchanged; no extra frame follows.
5. rst_n low at bit 4 of a write:
   - ssel=1, sclk=0, mosi=0 in the same clk with no done.
   - After release, a write of 0x81 completes correctly.
6. CLK_DIV=1 and CLK_DIV=5:
   - sclk period is 2 and 10 clks respectively.
   - Accept-to-done latency falls within the specified bounds.
   - No X on any output after reset.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator and the slave it drives:
// master FSM states, frame width and the slave-side state encodings.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    CMD  = 3'd2,
    DATA = 3'd3,
    GAP  = 3'd4
  } spi_mst_state_e;

  // Slave state encodings, kept here so the slave and its checkers agree.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WR   = 2'b01;
  localparam logic [1:0] ST_RD   = 2'b10;

endpackage

// File: rtl/spi_clk_div.sv
// Free-running SPI clock generator (mode 0, idle low). Ticks flag the
// system clock edge on which sclk rises or falls.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;
  logic          toggle;

  always_comb begin
    toggle    = (div_cnt_q == CW'(CLK_DIV - 1));
    div_cnt_d = toggle ? '0 : div_cnt_q + CW'(1);
    sclk_d    = toggle ? ~sclk_q : sclk_q;
    // Ticks are decoded from the current level so they coincide with the edge.
    rise_tick = toggle & ~sclk_q;
    fall_tick = toggle & sclk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: one 8-bit read or write per host request. Frame is one
// command sclk period followed by DATA_W data periods, MSB first.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int DATA_W   = SPI_DATA_W,
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rd_wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              sclk,
  output logic              ssel,
  output logic              rd_wr,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  // Host handshake: a request transfers on any clk edge where start and
  // ready are both high; rd_wr_req and wr_data are captured on that edge
  // only, and start seen while ready is low is dropped, not queued.

  logic rise_tick, fall_tick;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  spi_mst_state_e    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              dir_q, dir_d;
  logic              ssel_q, ssel_d;
  logic              rd_wr_q, rd_wr_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    rd_data_d = rd_data_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    dir_d     = dir_q;
    ssel_d    = ssel_q;
    rd_wr_d   = rd_wr_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d   = rd_wr_req;
          shift_d = wr_data;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (fall_tick) begin
          ssel_d  = 1'b0;
          rd_wr_d = dir_q;
          mosi_d  = 1'b0;
          state_d = CMD;
        end
      end

      // One full sclk period lets the slave leave its idle state.
      CMD: begin
        if (fall_tick) begin
          state_d   = DATA;
          bit_cnt_d = BW'(DATA_W - 1);
          mosi_d    = dir_q & shift_q[DATA_W-1];
        end
      end

      DATA: begin
        if (rise_tick) begin
          if (!dir_q) begin
            shift_d = {shift_q[DATA_W-2:0], miso};
          end
        end else if (fall_tick) begin
          if (bit_cnt_q == '0) begin
            state_d   = GAP;
            ssel_d    = 1'b1;
            mosi_d    = 1'b0;
            done_d    = 1'b1;
            gap_cnt_d = GW'(IDLE_GAP - 1);
            if (!dir_q) begin
              rd_data_d = shift_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - BW'(1);
            if (dir_q) begin
              shift_d = {shift_q[DATA_W-2:0], 1'b0};
              mosi_d  = shift_q[DATA_W-2];
            end
          end
        end
      end

      // rd_wr deliberately holds here; it only moves at WAIT->CMD.
      GAP: begin
        if (fall_tick) begin
          if (gap_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q - GW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      rd_data_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      dir_q     <= 1'b0;
      ssel_q    <= 1'b1;
      rd_wr_q   <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rd_data_q <= rd_data_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      dir_q     <= dir_d;
      ssel_q    <= ssel_d;
      rd_wr_q   <= rd_wr_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = ~ready;
  assign done    = done_q;
  assign rd_data = rd_data_q;
  assign ssel    = ssel_q;
  assign rd_wr   = rd_wr_q;
  assign mosi    = mosi_q;

  a_done_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(done && ready));

  a_serial_on_fall: assert property (@(posedge clk) disable iff (!rst_n)
    ((ssel_d != ssel_q) || (mosi_d != mosi_q) || (rd_wr_d != rd_wr_q)) |-> fall_tick);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: slave model plus scoreboard on the main
// instance (CLK_DIV=2, IDLE_GAP=2), timing checks on CLK_DIV=1 and 5.
module tb_spi_master_ctrl;

  localparam int W    = 8;
  localparam int DIV  = 2;
  localparam int GAPN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     = 1'b0;
  logic         start     = 1'b0;
  logic         rd_wr_req = 1'b0;
  logic [W-1:0] wr_data   = '0;
  logic         miso      = 1'b0;
  logic         ready, busy, done, sclk, ssel, rd_wr, mosi;
  logic [W-1:0] rd_data;

  spi_master_ctrl #(.CLK_DIV(DIV), .DATA_W(W), .IDLE_GAP(GAPN)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_wr_req(rd_wr_req),
    .wr_data(wr_data), .ready(ready), .busy(busy), .done(done),
    .rd_data(rd_data), .sclk(sclk), .ssel(ssel), .rd_wr(rd_wr),
    .mosi(mosi), .miso(miso)
  );

  // Timing-only instances: fixed write payload, miso tied low.
  logic [1:0]   f_start = 2'b00;
  logic [1:0]   f_ready, f_busy, f_done, f_sclk, f_ssel, f_rd_wr, f_mosi;
  logic [W-1:0] f_rd_data0, f_rd_data1;

  spi_master_ctrl #(.CLK_DIV(1), .DATA_W(W), .IDLE_GAP(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .start(f_start[0]), .rd_wr_req(1'b1),
    .wr_data(8'hC3), .ready(f_ready[0]), .busy(f_busy[0]), .done(f_done[0]),
    .rd_data(f_rd_data0), .sclk(f_sclk[0]), .ssel(f_ssel[0]), .rd_wr(f_rd_wr[0]),
    .mosi(f_mosi[0]), .miso(1'b0)
  );

  spi_master_ctrl #(.CLK_DIV(5), .DATA_W(W), .IDLE_GAP(1)) u_div5 (
    .clk(clk), .rst_n(rst_n), .start(f_start[1]), .rd_wr_req(1'b1),
    .wr_data(8'hC3), .ready(f_ready[1]), .busy(f_busy[1]), .done(f_done[1]),
    .rd_data(f_rd_data1), .sclk(f_sclk[1]), .ssel(f_ssel[1]), .rd_wr(f_rd_wr[1]),
    .mosi(f_mosi[1]), .miso(1'b0)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [W-1:0] exp_q[$];   // expected byte on mosi (0 for reads)
  logic [W-1:0] dir_q[$];   // expected rd_wr level for the frame
  logic [W-1:0] rdx_q[$];   // expected rd_data at done
  logic [W-1:0] model_rd    = '0;
  logic [W-1:0] slave_byte  = '0;
  int           acc_cnt     = 0;
  int           done_cnt    = 0;
  logic         aborting    = 1'b0;

  // Accept and done monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      dir_q.delete();
      rdx_q.delete();
      model_rd = '0;
    end else begin
      if (start && ready) begin
        acc_cnt++;
        exp_q.push_back(rd_wr_req ? wr_data : '0);
        dir_q.push_back({7'b0, rd_wr_req});
        if (!rd_wr_req) model_rd = slave_byte;
        rdx_q.push_back(model_rd);
      end
      if (done) begin
        done_cnt++;
        check("done_vs_ready", {31'b0, ready}, 0);
        if (rdx_q.size() == 0) check("done_unexpected", 1, 0);
        else check("rd_data_at_done", {24'b0, rd_data}, {24'b0, rdx_q.pop_front()});
      end
    end
  end

  // Slave model: counts sclk rises while ssel is low, drives miso MSB first
  // from the second rise on, collects mosi on rises 2..9.
  initial begin
    int           cnt;
    logic [W-1:0] mos, sb;
    logic         dir0, dir_ok, gap_valid;
    longint       prev_end;
    gap_valid = 1'b0;
    prev_end  = 0;
    forever begin
      @(negedge ssel);
      if (rst_n === 1'b1) begin
        cnt = 0; mos = '0; dir0 = 1'b0; dir_ok = 1'b1; sb = slave_byte;
        if (gap_valid) check("ssel_gap", {31'b0, (($time - prev_end) / 10) >= GAPN * 2 * DIV}, 1);
        while (ssel === 1'b0) begin
          @(posedge sclk or posedge ssel);
          if (ssel === 1'b0) begin
            #1;
            cnt++;
            if (cnt == 1) dir0 = rd_wr;
            else if (rd_wr !== dir0) dir_ok = 1'b0;
            if (cnt >= 2 && cnt <= 9) mos = {mos[W-2:0], mosi};
            check("mosi_known", {31'b0, $isunknown(mosi)}, 0);
            if (cnt <= 8) miso = sb[8-cnt];
          end
        end
        miso = 1'b0;
        if (aborting) begin
          gap_valid = 1'b0;
        end else begin
          check("sclk_edges", cnt, 9);
          check("rd_wr_stable", {31'b0, dir_ok}, 1);
          if (exp_q.size() == 0) begin
            check("frame_unexpected", 1, 0);
          end else begin
            check("rd_wr_dir", {31'b0, dir0}, {24'b0, dir_q.pop_front()});
            check("mosi_byte", {24'b0, mos}, {24'b0, exp_q.pop_front()});
          end
          prev_end  = $time;
          gap_valid = 1'b1;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    if (ready !== 1'b1) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic dir, input logic [W-1:0] d);
    @(posedge clk); #1;
    wait_ready();
    rd_wr_req = dir;
    wr_data   = d;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done_cnt(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(negedge clk); n++; end
    check("done_wait", {31'b0, done_cnt >= target}, 1);
  endtask

  task automatic wait_ssel_low();
    int n = 0;
    while (ssel !== 1'b0 && n < 500) begin @(posedge clk); #1; n++; end
    check("ssel_low_wait", {31'b0, ssel}, 0);
  endtask

  task automatic timing_probe(input int idx, input int div);
    int   r1, r2, n, lat;
    logic prev;
    r1 = -1; r2 = -1;
    @(negedge clk);
    prev = f_sclk[idx];
    for (int i = 0; i < 100 && r2 < 0; i++) begin
      @(negedge clk);
      if (f_sclk[idx] && !prev) begin
        if (r1 < 0) r1 = i;
        else r2 = i;
      end
      prev = f_sclk[idx];
    end
    check("sclk_period", r2 - r1, 2 * div);
    @(posedge clk); #1;
    n = 0;
    while (f_ready[idx] !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
    f_start[idx] = 1'b1;
    @(posedge clk); #1;
    f_start[idx] = 1'b0;
    n = 0;
    while (f_done[idx] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    lat = n - 1;
    check("latency_lo", {31'b0, lat >= 18 * div}, 1);
    check("latency_hi", {31'b0, lat <= 20 * div}, 1);
    check("no_x_small", {31'b0, $isunknown({f_ready[idx], f_busy[idx], f_done[idx], f_sclk[idx],
                                             f_ssel[idx], f_rd_wr[idx], f_mosi[idx]})}, 0);
  endtask

  initial begin
    int a0, d0, n;

    // Reset values
    repeat (3) @(posedge clk);
    #3;
    check("rst_sclk",    {31'b0, sclk}, 0);
    check("rst_ssel",    {31'b0, ssel}, 1);
    check("rst_rd_wr",   {31'b0, rd_wr}, 0);
    check("rst_mosi",    {31'b0, mosi}, 0);
    check("rst_done",    {31'b0, done}, 0);
    check("rst_rd_data", {24'b0, rd_data}, 0);
    check("rst_ready",   {31'b0, ready}, 1);
    check("rst_busy",    {31'b0, busy}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("no_x_main", {31'b0, $isunknown({ready, busy, done, rd_data, sclk, ssel, rd_wr, mosi})}, 0);

    // Write 0xA5
    send(1'b1, 8'hA5);
    wait_done_cnt(1);

    // Read 0x3C, then a write must leave rd_data alone
    slave_byte = 8'h3C;
    send(1'b0, 8'h00);
    wait_done_cnt(2);
    check("rd_after_read", {24'b0, rd_data}, 32'h3C);
    send(1'b1, 8'h5A);
    wait_done_cnt(3);
    check("rd_after_write", {24'b0, rd_data}, 32'h3C);

    // start held high for three frames; payload churns while busy
    a0 = acc_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    wait_ready();
    rd_wr_req = 1'b1;
    wr_data   = W'($urandom_range(0, 255));
    start     = 1'b1;
    n = 0;
    while (acc_cnt < a0 + 3 && n < 2000) begin
      @(posedge clk); #1;
      if (busy) wr_data = W'($urandom_range(0, 255));
      n++;
    end
    start = 1'b0;
    check("held_accepts", acc_cnt - a0, 3);
    wait_done_cnt(d0 + 3);
    repeat (100) @(posedge clk);
    check("held_done_count", done_cnt - d0, 3);

    // start pulsed mid-frame is dropped
    a0 = acc_cnt; d0 = done_cnt;
    send(1'b1, 8'h96);
    wait_ssel_low();
    repeat (12) @(posedge clk);
    #1;
    rd_wr_req = 1'b0; wr_data = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done_cnt(d0 + 1);
    repeat (100) @(posedge clk);
    check("busy_start_accepts", acc_cnt - a0, 1);
    check("busy_start_dones", done_cnt - d0, 1);

    // Reset in the middle of a write
    d0 = done_cnt;
    send(1'b1, 8'h0F);
    wait_ssel_low();
    repeat (6 * 2 * DIV) @(posedge clk);
    #3;
    aborting = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("abort_ssel",  {31'b0, ssel}, 1);
    check("abort_sclk",  {31'b0, sclk}, 0);
    check("abort_mosi",  {31'b0, mosi}, 0);
    check("abort_done",  {31'b0, done}, 0);
    check("abort_ready", {31'b0, ready}, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    aborting = 1'b0;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_rd_data", {24'b0, rd_data}, 0);
    send(1'b1, 8'h81);
    wait_done_cnt(d0 + 1);

    // Random mix of reads and writes
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      slave_byte = W'($urandom_range(0, 255));
      send(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)));
      wait_done_cnt(d0 + 1);
    end

    // Divider extremes
    timing_probe(0, 1);
    timing_probe(1, 5);

    repeat (50) @(posedge clk);
    check("scoreboard_empty", exp_q.size() + dir_q.size() + rdx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
